// File: rtl/lsu_bus_ctrl_pkg.sv
// lsu_bus_ctrl_pkg: command/size encodings, FSM states and alignment helper for the LSU
package lsu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_OTHER = 2'b00,
        CMD_JMP   = 2'b01,
        CMD_ST    = 2'b10,
        CMD_LW    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Reserved size behaves as a word, so anything that is not byte/half needs a word boundary
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lo[0] : |lo;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: data-side request/grant/ack system bus
interface lsu_bus_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input gnt, ack, err, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, ack, err, rdata);
endinterface

// File: rtl/lsu_bus_ctrl_lane.sv
// lsu_bus_ctrl_lane: byte-enable generation, store lane replication, load extraction/extension
module lsu_bus_ctrl_lane
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  b;
    logic [15:0] h;

    // Lane steering is purely a function of the latched size/offset
    always_comb begin
        b         = 8'(rdata >> {lo, 3'b000});
        h         = 16'(rdata >> {lo[1], 4'b0000});
        be        = size == SZ_BYTE ? 4'b0001 << lo
                  : size == SZ_HALF ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}}
                  : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        rdata_ext = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b}
                  : size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : rdata;
    end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: M-stage load/store bus responder producing active-low stall/ack for the hazard unit
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           cmd_in,
    input  logic [1:0]           size_in,
    input  logic                 uns_in,
    input  logic [AW-1:0]        addr_in,
    input  logic [DW-1:0]        wdata_in,
    output logic                 stal_out,
    output logic                 ack_out,
    output logic [DW-1:0]        rdata_out,
    output logic                 misalign_out,
    output logic                 buserr_out,
    lsu_bus_ctrl_if.master       bus
);
    state_e        state, state_nx;
    logic [7:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          mem, mis, start, fail, act;
    logic [3:0]    be;
    logic [31:0]   wrep, rext;

    assign mem   = cmd_in == CMD_LW || cmd_in == CMD_ST;
    assign mis   = misaligned(size_in, addr_in[1:0]);
    assign start = state == S_IDLE && mem && !mis;
    assign fail  = bus.err || cnt == 8'(TMO);
    assign act   = state == S_REQ || state == S_WAIT;

    lsu_bus_ctrl_lane u_lane (
        .size      (size_q),
        .uns       (uns_q),
        .lo        (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus.rdata),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next state, pipeline handshake levels and bus drive (bus is quiet outside REQ/WAIT)
    always_comb begin
        state_nx  = state;
        stal_out  = 1'b1;
        ack_out   = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.be    = '0;
        bus.wdata = '0;
        case (state)
            S_IDLE: begin
                stal_out = !start;
                state_nx = start ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                stal_out = 1'b0;
                bus.req  = 1'b1;
                state_nx = bus.gnt ? S_WAIT : S_REQ;
            end
            S_WAIT: begin
                ack_out  = 1'b0;
                state_nx = (bus.ack || fail) ? S_RESP : S_WAIT;
            end
            default: state_nx = S_IDLE;
        endcase
        if (act) begin
            bus.we    = we_q;
            bus.addr  = {addr_q[AW-1:2], 2'b00};
            bus.be    = be;
            bus.wdata = wrep;
        end
    end

    // Command capture, wait counter, load data and one-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            rdata_out    <= '0;
            misalign_out <= 1'b0;
            buserr_out   <= 1'b0;
        end else begin
            cnt          <= state == S_WAIT ? cnt + 8'd1 : 8'd0;
            misalign_out <= state == S_IDLE && mem && mis;
            buserr_out   <= state == S_WAIT && fail;
            if (start) begin
                addr_q  <= addr_in;
                size_q  <= size_in;
                uns_q   <= uns_in;
                we_q    <= cmd_in == CMD_ST;
                wdata_q <= wdata_in;
            end
            if (state == S_IDLE && mem && mis) rdata_out <= '0;
            else if (state == S_WAIT && fail) rdata_out <= '0;
            else if (state == S_WAIT && bus.ack && !we_q) rdata_out <= rext;
        end
    end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: scoreboard bench for the LSU bus controller
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cmd_in = 2'b00;
    logic [1:0]  size_in = 2'b00;
    logic        uns_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic        stal_out, ack_out, misalign_out, buserr_out;
    logic [31:0] rdata_out;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    lsu_bus_ctrl_if #(.AW(32), .DW(32)) bus ();

    lsu_bus_ctrl #(.AW(32), .DW(32), .TMO(255)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_in       (cmd_in),
        .size_in      (size_in),
        .uns_in       (uns_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .stal_out     (stal_out),
        .ack_out      (ack_out),
        .rdata_out    (rdata_out),
        .misalign_out (misalign_out),
        .buserr_out   (buserr_out),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ext_b(input logic [31:0] rd, input int lane, input logic uns);
        logic [7:0] b;
        b = rd[8*lane +: 8];
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    // mode: 0 ack, 1 err only, 2 ack+err, 3 no response (timeout)
    task automatic run_op(input logic [1:0] cmd, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int gdly, input int adly, input int mode,
                          input logic [3:0] be, input logic [31:0] bw, input logic [31:0] erd);
        exp_t e, cur;
        int   n;
        e.we    = (cmd == CMD_ST);
        e.addr  = {addr[31:2], 2'b00};
        e.be    = be;
        e.wdata = bw;
        e.err   = (mode != 0);
        e.rdata = e.err ? 32'h0 : erd;
        cmd_in = cmd; size_in = size; uns_in = uns; addr_in = addr; wdata_in = wd;
        sb.push_back(e);
        #1 chk("stal_idle", stal_out, 0);
        chk("ack_idle", ack_out, 1);
        @(negedge clk);
        cmd_in = CMD_OTHER;
        cur = sb.pop_front();
        chk("req", bus.req, 1);
        chk("stal_req", stal_out, 0);
        chk("ack_req", ack_out, 1);
        chk("we", bus.we, cur.we);
        chk("bus_addr", bus.addr, cur.addr);
        chk("bus_be", bus.be, cur.be);
        chk("bus_wdata", bus.wdata, cur.wdata);
        repeat (gdly) begin
            @(negedge clk);
            chk("req_hold", bus.req, 1);
        end
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        chk("ack_wait", ack_out, 0);
        chk("stal_wait", stal_out, 1);
        chk("req_wait", bus.req, 0);
        chk("be_wait", bus.be, cur.be);
        if (mode == 3) begin
            n = 0;
            while (ack_out == 1'b0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_window", (n >= 255 && n <= 257), 1);
        end else begin
            repeat (adly) begin
                @(negedge clk);
                chk("ack_hold", ack_out, 0);
            end
            bus.ack = (mode == 0 || mode == 2);
            bus.err = (mode == 1 || mode == 2);
            bus.rdata = rd;
            @(negedge clk);
            bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
        end
        chk("ack_resp", ack_out, 1);
        chk("stal_resp", stal_out, 1);
        chk("rdata", rdata_out, cur.rdata);
        chk("buserr", buserr_out, cur.err);
        last_rd = cur.rdata;
        @(negedge clk);
        chk("buserr_clr", buserr_out, 0);
        chk("be_idle", bus.be, 0);
        chk("stal_back", stal_out, 1);
    endtask

    task automatic mis_op(input logic [1:0] cmd, input logic [1:0] size, input logic [31:0] addr);
        cmd_in = cmd; size_in = size; addr_in = addr;
        #1 chk("mis_stal", stal_out, 1);
        chk("mis_ack", ack_out, 1);
        @(negedge clk);
        cmd_in = CMD_OTHER;
        chk("mis_pulse", misalign_out, 1);
        chk("mis_rdata", rdata_out, 0);
        chk("mis_req", bus.req, 0);
        @(negedge clk);
        chk("mis_clr", misalign_out, 0);
        chk("mis_req2", bus.req, 0);
        last_rd = '0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_stal", stal_out, 1);
        chk("rst_ack", ack_out, 1);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_mis", misalign_out, 0);
        chk("rst_err", buserr_out, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_be", bus.be, 0);
        chk("rst_wdata", bus.wdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.gnt = 1'b0; bus.ack = 1'b0; bus.err = 1'b0; bus.rdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;
        @(negedge clk);

        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
        run_op(CMD_LW, SZ_BYTE, 1'b0, 32'h203, 32'h0, 32'h80FFFFFF, 0, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
        run_op(CMD_LW, SZ_BYTE, 1'b1, 32'h203, 32'h0, 32'h80FFFFFF, 0, 0, 0, 4'b1000, 32'h0, 32'h00000080);
        for (int i = 0; i < 4; i++)
            for (int u = 0; u < 2; u++)
                run_op(CMD_LW, SZ_BYTE, u[0], 32'h210 + i, 32'h0, 32'h8A7B4CBD, 0, 0, 0,
                       4'b0001 << i, 32'h0, ext_b(32'h8A7B4CBD, i, u[0]));
        run_op(CMD_LW, SZ_HALF, 1'b0, 32'h202, 32'h0, 32'h80011234, 0, 0, 0, 4'b1100, 32'h0, 32'hFFFF8001);
        run_op(CMD_LW, SZ_HALF, 1'b1, 32'h200, 32'h0, 32'h8001F234, 0, 0, 0, 4'b0011, 32'h0, 32'h0000F234);
        run_op(CMD_ST, SZ_HALF, 1'b0, 32'h302, 32'h1234ABCD, 32'h0, 0, 0, 0, 4'b1100, 32'hABCDABCD, last_rd);
        run_op(CMD_ST, SZ_BYTE, 1'b0, 32'h301, 32'h0000005A, 32'h0, 0, 0, 0, 4'b0010, 32'h5A5A5A5A, last_rd);
        run_op(CMD_ST, SZ_WORD, 1'b0, 32'h500, 32'hCAFEF00D, 32'h0, 2, 3, 0, 4'b1111, 32'hCAFEF00D, last_rd);
        run_op(CMD_LW, SZ_RSVD, 1'b0, 32'h600, 32'h0, 32'h11223344, 1, 1, 0, 4'b1111, 32'h0, 32'h11223344);

        mis_op(CMD_LW, SZ_WORD, 32'h101);
        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 0, 0, 0, 4'b1111, 32'h0, 32'h0BADF00D);
        mis_op(CMD_ST, SZ_HALF, 32'h103);

        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h600, 32'h0, 32'h77777777, 0, 0, 0, 4'b1111, 32'h0, 32'h77777777);
        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h700, 32'h0, 32'h55555555, 0, 1, 1, 4'b1111, 32'h0, 32'h0);
        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h600, 32'h0, 32'h66666666, 0, 0, 0, 4'b1111, 32'h0, 32'h66666666);
        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h704, 32'h0, 32'h55555555, 0, 0, 2, 4'b1111, 32'h0, 32'h0);

        cmd_in = CMD_JMP; size_in = SZ_WORD; addr_in = 32'h800;
        #1 chk("jmp_stal", stal_out, 1);
        @(negedge clk);
        chk("jmp_req", bus.req, 0);
        chk("jmp_stal2", stal_out, 1);
        cmd_in = CMD_OTHER;
        @(negedge clk);

        run_op(CMD_LW, SZ_WORD, 1'b0, 32'h900, 32'h0, 32'h13579BDF, 0, 0, 0, 4'b1111, 32'h0, 32'h13579BDF);
        cmd_in = CMD_LW; size_in = SZ_WORD; addr_in = 32'hA00;
        @(negedge clk);
        cmd_in = CMD_OTHER;
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        chk("pre_rst_ack", ack_out, 0);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        run_op(CMD_LW, SZ_WORD, 1'b0, 32'hA04, 32'h0, 32'h2468ACE0, 0, 0, 0, 4'b1111, 32'h0, 32'h2468ACE0);

        run_op(CMD_LW, SZ_WORD, 1'b0, 32'hB00, 32'h0, 32'h0, 0, 0, 3, 4'b1111, 32'h0, 32'h0);
        chk("tmo_ack_idle", ack_out, 1);
        chk("tmo_req_idle", bus.req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
